// File: rtl/axi_lat_pkg.sv
// Shared types for the AXI latency profiler: run mode, window state and default log slot width.
package axi_lat_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_RD   = 2'd1,
      MODE_WR   = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CNT  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_LOG_ID_W = 4;

endpackage

// File: rtl/lat_id_table.sv
// Per-ID request timestamp table: one allocate port, one retire port with a combinational lookup.
module lat_id_table
   import axi_lat_pkg::*;
#(
   parameter int  NUM_IDS = 16,
   parameter int  CNT_W   = 64,
   localparam int IDX_W   = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] i_now,
   input  logic             i_alloc,
   input  logic [IDX_W-1:0] i_alloc_idx,
   input  logic             i_retire,
   input  logic [IDX_W-1:0] i_retire_idx,
   output logic             o_retire_hit,
   output logic [CNT_W-1:0] o_retire_stamp,
   output logic             o_dup,
   output logic             o_orphan
);

   logic [NUM_IDS-1:0] r_valid;
   logic [CNT_W-1:0]   r_stamp [NUM_IDS];
   logic               w_same_idx;

   // A retire on the same index frees the entry first, so the new request is not a duplicate
   assign w_same_idx     = i_retire && i_alloc && (i_retire_idx == i_alloc_idx);
   assign o_retire_hit   = i_retire && r_valid[i_retire_idx];
   assign o_retire_stamp = r_stamp[i_retire_idx];
   assign o_orphan       = i_retire && !r_valid[i_retire_idx];
   assign o_dup          = i_alloc && r_valid[i_alloc_idx] && !w_same_idx;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_valid <= '0;
      end else begin
         if (o_retire_hit) r_valid[i_retire_idx] <= 1'b0;
         if (i_alloc)      r_valid[i_alloc_idx]  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_alloc) r_stamp[i_alloc_idx] <= i_now;
   end

endmodule

// File: rtl/axi_lat_profiler.sv
// Passive AXI latency profiler: taps the read or write channel set of one master port and
// accumulates window timing, per-request latency statistics, ID logs and protocol error flags.
module axi_lat_profiler
   import axi_lat_pkg::*;
#(
   parameter int ID_W      = 12,
   parameter int NUM_IDS   = 16,
   parameter int LOG_DEPTH = 16,
   parameter int LOG_ID_W  = DEF_LOG_ID_W,
   parameter int CNT_W     = 64
)(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clear,
   input  logic [1:0]                    mode,
   input  logic [CNT_W-1:0]              num_request,
   input  logic                          arvalid,
   input  logic                          arready,
   input  logic                          awvalid,
   input  logic                          awready,
   input  logic [ID_W-1:0]               arid,
   input  logic [ID_W-1:0]               awid,
   input  logic                          rvalid,
   input  logic                          rready,
   input  logic                          rlast,
   input  logic [ID_W-1:0]               rid,
   input  logic                          wvalid,
   input  logic                          wready,
   input  logic                          bvalid,
   input  logic                          bready,
   input  logic [ID_W-1:0]               bid,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              total_cycles,
   output logic [CNT_W-1:0]              first_resp_cycles,
   output logic [CNT_W-1:0]              lat_min,
   output logic [CNT_W-1:0]              lat_max,
   output logic [CNT_W-1:0]              lat_sum,
   output logic [CNT_W-1:0]              req_cnt,
   output logic [CNT_W-1:0]              resp_cnt,
   output logic [CNT_W-1:0]              beat_cnt,
   output logic [LOG_DEPTH*LOG_ID_W-1:0] req_id_log,
   output logic [LOG_DEPTH*LOG_ID_W-1:0] resp_id_log,
   output logic                          err_orphan,
   output logic                          err_dup
);

   localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

   mode_e                        w_mode;
   logic                         w_rd, w_wr, w_active;
   logic                         w_req, w_resp, w_beat;
   logic [ID_W-1:0]              w_req_id, w_resp_id;
   logic [CNT_W-1:0]             w_target, w_lat, w_stamp;
   logic                         w_hit, w_dup, w_orphan;
   logic                         w_unused_id;

   state_e                       r_state;
   logic                         r_busy, r_done;
   logic [CNT_W-1:0]             r_now, r_total, r_first;
   logic [CNT_W-1:0]             r_lat_min, r_lat_max, r_lat_sum;
   logic [CNT_W-1:0]             r_req_cnt, r_resp_cnt, r_beat_cnt;
   logic [LOG_DEPTH*LOG_ID_W-1:0] r_req_log, r_resp_log;
   logic                         r_err_orphan, r_err_dup;

   // Everything is frozen once the window has closed or when no channel set is selected
   assign w_mode    = mode_e'(mode);
   assign w_rd      = (w_mode == MODE_RD);
   assign w_wr      = (w_mode == MODE_WR);
   assign w_active  = (w_rd || w_wr) && (r_state != ST_DONE);
   assign w_req     = w_active && (w_rd ? (arvalid && arready) : (awvalid && awready));
   assign w_resp    = w_active && (w_rd ? (rvalid && rready && rlast) : (bvalid && bready));
   assign w_beat    = w_active && (w_rd ? (rvalid && rready) : (wvalid && wready));
   assign w_req_id  = w_rd ? arid : awid;
   assign w_resp_id = w_rd ? rid : bid;
   assign w_target  = (num_request == '0) ? CNT_W'(1) : num_request;
   assign w_lat     = r_now - w_stamp;
   assign w_unused_id = ^{w_req_id, w_resp_id};

   lat_id_table #(
      .NUM_IDS (NUM_IDS),
      .CNT_W   (CNT_W)
   ) u_table (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (clear),
      .i_now          (r_now),
      .i_alloc        (w_req),
      .i_alloc_idx    (w_req_id[IDX_W-1:0]),
      .i_retire       (w_resp),
      .i_retire_idx   (w_resp_id[IDX_W-1:0]),
      .o_retire_hit   (w_hit),
      .o_retire_stamp (w_stamp),
      .o_dup          (w_dup),
      .o_orphan       (w_orphan)
   );

   always_ff @(posedge clk) begin
      if (!reset_n || clear) r_now <= '0;
      else                   r_now <= r_now + CNT_W'(1);
   end

   // Window FSM: total/first-response timers run only while counting
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_total <= '0;
         r_first <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_state <= ST_CNT;
                  r_busy  <= 1'b1;
                  r_total <= '0;
                  r_first <= '0;
               end
            end
            ST_CNT: begin
               r_total <= r_total + CNT_W'(1);
               if (r_resp_cnt == '0) r_first <= r_first + CNT_W'(1);
               if (w_resp && ((r_resp_cnt + CNT_W'(1)) >= w_target)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Counters, latency statistics, ID logs and sticky error flags
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_req_cnt    <= '0;
         r_resp_cnt   <= '0;
         r_beat_cnt   <= '0;
         r_lat_min    <= '1;
         r_lat_max    <= '0;
         r_lat_sum    <= '0;
         r_req_log    <= '0;
         r_resp_log   <= '0;
         r_err_orphan <= 1'b0;
         r_err_dup    <= 1'b0;
      end else begin
         if (w_req)  r_req_cnt  <= r_req_cnt + CNT_W'(1);
         if (w_resp) r_resp_cnt <= r_resp_cnt + CNT_W'(1);
         if (w_beat) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         if (w_hit) begin
            r_lat_sum <= r_lat_sum + w_lat;
            if (w_lat < r_lat_min) r_lat_min <= w_lat;
            if (w_lat > r_lat_max) r_lat_max <= w_lat;
         end
         for (int k = 0; k < LOG_DEPTH; k++) begin
            if (w_req && (r_req_cnt == CNT_W'(k)))
               r_req_log[k*LOG_ID_W +: LOG_ID_W] <= w_req_id[LOG_ID_W-1:0];
            if (w_resp && (r_resp_cnt == CNT_W'(k)))
               r_resp_log[k*LOG_ID_W +: LOG_ID_W] <= w_resp_id[LOG_ID_W-1:0];
         end
         r_err_orphan <= r_err_orphan | w_orphan;
         r_err_dup    <= r_err_dup | w_dup;
      end
   end

   assign busy              = r_busy;
   assign done              = r_done;
   assign total_cycles      = r_total;
   assign first_resp_cycles = r_first;
   assign lat_min           = r_lat_min;
   assign lat_max           = r_lat_max;
   assign lat_sum           = r_lat_sum;
   assign req_cnt           = r_req_cnt;
   assign resp_cnt          = r_resp_cnt;
   assign beat_cnt          = r_beat_cnt;
   assign req_id_log        = r_req_log;
   assign resp_id_log       = r_resp_log;
   assign err_orphan        = r_err_orphan;
   assign err_dup           = r_err_dup;

endmodule

// File: tb/tb_axi_lat_profiler.sv
// Self-checking bench for axi_lat_profiler: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model kept in the bench.
module tb_axi_lat_profiler;

   localparam int ID_W = 12, NUM_IDS = 16, LOG_DEPTH = 16, LOG_ID_W = 4, CNT_W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0, clear = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [CNT_W-1:0] num_request = '0;
   logic arvalid = 0, arready = 0, awvalid = 0, awready = 0;
   logic [ID_W-1:0] arid = '0, awid = '0, rid = '0, bid = '0;
   logic rvalid = 0, rready = 0, rlast = 0, wvalid = 0, wready = 0, bvalid = 0, bready = 0;
   logic busy, done, err_orphan, err_dup;
   logic [CNT_W-1:0] total_cycles, first_resp_cycles, lat_min, lat_max, lat_sum;
   logic [CNT_W-1:0] req_cnt, resp_cnt, beat_cnt;
   logic [LOG_DEPTH*LOG_ID_W-1:0] req_id_log, resp_id_log;

   axi_lat_profiler #(
      .ID_W(ID_W), .NUM_IDS(NUM_IDS), .LOG_DEPTH(LOG_DEPTH), .LOG_ID_W(LOG_ID_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode), .num_request(num_request),
      .arvalid(arvalid), .arready(arready), .awvalid(awvalid), .awready(awready),
      .arid(arid), .awid(awid), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
      .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready), .bid(bid),
      .busy(busy), .done(done), .total_cycles(total_cycles), .first_resp_cycles(first_resp_cycles),
      .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
      .req_cnt(req_cnt), .resp_cnt(resp_cnt), .beat_cnt(beat_cnt),
      .req_id_log(req_id_log), .resp_id_log(resp_id_log),
      .err_orphan(err_orphan), .err_dup(err_dup)
   );

   int testCount = 0;
   int failCount = 0;
   bit chkEn = 1'b0;

   // Transaction-level model: absolute times of window events plus a map of outstanding stamps
   logic [63:0] mNow, mT0, mFirstT, mFinT;
   bit          mStarted, mFinished, mFirstKnown, mDup, mOrphan;
   logic [63:0] mReqCnt, mRespCnt, mBeatCnt, mLatMin, mLatMax, mLatSum;
   bit          mValid [NUM_IDS];
   logic [63:0] mStamp [NUM_IDS];
   logic [3:0]  mReqLog [LOG_DEPTH];
   logic [3:0]  mRespLog [LOG_DEPTH];
   logic [63:0] eTotal, eFirst;

   task automatic modelReset();
      mNow = 0; mT0 = 0; mFirstT = 0; mFinT = 0;
      mStarted = 0; mFinished = 0; mFirstKnown = 0; mDup = 0; mOrphan = 0;
      mReqCnt = 0; mRespCnt = 0; mBeatCnt = 0;
      mLatMin = '1; mLatMax = 0; mLatSum = 0;
      eTotal = 0; eFirst = 0;
      for (int i = 0; i < NUM_IDS; i++) begin mValid[i] = 0; mStamp[i] = 0; end
      for (int i = 0; i < LOG_DEPTH; i++) begin mReqLog[i] = 0; mRespLog[i] = 0; end
   endtask

   task automatic modelStep();
      bit act, rq, rs, bt, openedBefore;
      logic [ID_W-1:0] qId, sId;
      logic [63:0] lat, tgt;
      int qi, si;
      if (!reset_n || clear) begin
         modelReset();
         return;
      end
      act = (mode == 2'd1 || mode == 2'd2) && !mFinished;
      rq  = act && ((mode == 2'd1) ? (arvalid && arready) : (awvalid && awready));
      rs  = act && ((mode == 2'd1) ? (rvalid && rready && rlast) : (bvalid && bready));
      bt  = act && ((mode == 2'd1) ? (rvalid && rready) : (wvalid && wready));
      qId = (mode == 2'd1) ? arid : awid;
      sId = (mode == 2'd1) ? rid : bid;
      qi  = int'(qId[3:0]);
      si  = int'(sId[3:0]);
      tgt = (num_request == 0) ? 64'd1 : num_request;
      openedBefore = mStarted;
      if (rq && !mStarted) begin
         mStarted = 1; mT0 = mNow;
         if (mRespCnt != 0) begin mFirstKnown = 1; mFirstT = mNow; end
      end
      if (rs) begin
         if (mValid[si]) begin
            lat = mNow - mStamp[si];
            mLatSum = mLatSum + lat;
            if (lat < mLatMin) mLatMin = lat;
            if (lat > mLatMax) mLatMax = lat;
            mValid[si] = 0;
         end else begin
            mOrphan = 1;
         end
         if (mRespCnt < LOG_DEPTH) mRespLog[mRespCnt] = sId[3:0];
         mRespCnt++;
         if (mStarted && !mFirstKnown) begin mFirstKnown = 1; mFirstT = mNow; end
         if (openedBefore && mRespCnt >= tgt) begin mFinished = 1; mFinT = mNow; end
      end
      if (rq) begin
         if (mValid[qi]) mDup = 1;
         mValid[qi] = 1;
         mStamp[qi] = mNow;
         if (mReqCnt < LOG_DEPTH) mReqLog[mReqCnt] = qId[3:0];
         mReqCnt++;
      end
      if (bt) mBeatCnt++;
      eTotal = mStarted ? ((mFinished ? mFinT : mNow) - mT0) : 64'd0;
      eFirst = mStarted ? ((mFirstKnown ? mFirstT : mNow) - mT0) : 64'd0;
      mNow++;
   endtask

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkOutput();
      logic [63:0] qLog, sLog;
      for (int k = 0; k < LOG_DEPTH; k++) begin
         qLog[k*4 +: 4] = mReqLog[k];
         sLog[k*4 +: 4] = mRespLog[k];
      end
      cmp("busy", 64'(busy), 64'(mStarted && !mFinished));
      cmp("done", 64'(done), 64'(mFinished));
      cmp("total_cycles", total_cycles, eTotal);
      cmp("first_resp_cycles", first_resp_cycles, eFirst);
      cmp("lat_min", lat_min, mLatMin);
      cmp("lat_max", lat_max, mLatMax);
      cmp("lat_sum", lat_sum, mLatSum);
      cmp("req_cnt", req_cnt, mReqCnt);
      cmp("resp_cnt", resp_cnt, mRespCnt);
      cmp("beat_cnt", beat_cnt, mBeatCnt);
      cmp("req_id_log", req_id_log, qLog);
      cmp("resp_id_log", resp_id_log, sLog);
      cmp("err_orphan", 64'(err_orphan), 64'(mOrphan));
      cmp("err_dup", 64'(err_dup), 64'(mDup));
   endtask

   always @(negedge clk) if (chkEn) checkOutput();

   // One clock: model consumes the same inputs the DUT samples, then handshakes drop to idle
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      arvalid = 0; arready = 0; awvalid = 0; awready = 0;
      rvalid = 0; rready = 0; rlast = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clearPulse();
      clear = 1; tick(); clear = 0;
   endtask

   task automatic applyStimulus();
      arvalid = ($urandom_range(0, 3) == 0); arready = 1'($urandom);
      awvalid = ($urandom_range(0, 3) == 0); awready = 1'($urandom);
      arid = {8'($urandom), 4'($urandom_range(0, 7))};
      awid = {8'($urandom), 4'($urandom_range(0, 7))};
      rvalid = ($urandom_range(0, 2) == 0); rready = 1'($urandom); rlast = 1'($urandom);
      rid = {8'($urandom), 4'($urandom_range(0, 7))};
      wvalid = 1'($urandom); wready = 1'($urandom);
      bvalid = ($urandom_range(0, 3) == 0); bready = 1'($urandom);
      bid = {8'($urandom), 4'($urandom_range(0, 7))};
      if ($urandom_range(0, 249) == 0) clear = 1;
      tick();
      clear = 0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      modelReset();
      reset_n = 0;
      tick();
      chkEn = 1;
      tick();
      reset_n = 1;
      cmp("reset lat_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
      cmp("reset total", total_cycles, 64'd0);

      $display("[TB] read window, four IDs, latency 20 each");
      mode = 2'd1; num_request = 4;
      for (int i = 0; i < 4; i++) begin
         arvalid = 1; arready = 1; arid = 12'(i); tick();
      end
      ticks(16);
      for (int i = 0; i < 4; i++) begin
         rvalid = 1; rready = 1; rlast = 1; rid = 12'(i); tick();
      end
      tick();
      cmp("t1 done", 64'(done), 64'd1);
      cmp("t1 total", total_cycles, 64'd23);
      cmp("t1 first", first_resp_cycles, 64'd20);
      cmp("t1 lat_min", lat_min, 64'd20);
      cmp("t1 lat_max", lat_max, 64'd20);
      cmp("t1 lat_sum", lat_sum, 64'd80);
      cmp("t1 req_log", 64'(req_id_log[15:0]), 64'h3210);

      $display("[TB] write window, id5 reissued on the retiring cycle");
      clearPulse();
      mode = 2'd2; num_request = 2;
      awvalid = 1; awready = 1; awid = 12'd5; tick();
      wvalid = 1; wready = 1; tick();
      wvalid = 1; wready = 1; tick();
      ticks(7);
      bvalid = 1; bready = 1; bid = 12'd5; awvalid = 1; awready = 1; awid = 12'd5; tick();
      ticks(19);
      bvalid = 1; bready = 1; bid = 12'd5; tick();
      tick();
      cmp("t2 lat_min", lat_min, 64'd10);
      cmp("t2 lat_max", lat_max, 64'd20);
      cmp("t2 err_dup", 64'(err_dup), 64'd0);
      cmp("t2 resp_log", 64'(resp_id_log[7:0]), 64'h55);
      cmp("t2 done", 64'(done), 64'd1);

      $display("[TB] four-beat read burst");
      clearPulse();
      mode = 2'd1; num_request = 1;
      arvalid = 1; arready = 1; arid = 12'd2; tick();
      ticks(2);
      for (int i = 0; i < 4; i++) begin
         rvalid = 1; rready = 1; rid = 12'd2; rlast = (i == 3); tick();
      end
      tick();
      cmp("t3 beat_cnt", beat_cnt, 64'd4);
      cmp("t3 resp_cnt", resp_cnt, 64'd1);
      cmp("t3 lat_sum", lat_sum, 64'd6);

      $display("[TB] orphan write response");
      clearPulse();
      mode = 2'd2; num_request = 1;
      bvalid = 1; bready = 1; bid = 12'd7; tick();
      tick();
      cmp("t4 err_orphan", 64'(err_orphan), 64'd1);
      cmp("t4 lat_sum", lat_sum, 64'd0);
      cmp("t4 resp_cnt", resp_cnt, 64'd1);

      $display("[TB] clear with three outstanding");
      clearPulse();
      mode = 2'd1; num_request = 8;
      for (int i = 1; i < 4; i++) begin
         arvalid = 1; arready = 1; arid = 12'(i); tick();
      end
      ticks(3);
      clearPulse();
      cmp("t5 busy", 64'(busy), 64'd0);
      cmp("t5 req_cnt", req_cnt, 64'd0);
      cmp("t5 lat_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
      rvalid = 1; rready = 1; rlast = 1; rid = 12'd1; tick();
      tick();
      cmp("t5 err_orphan", 64'(err_orphan), 64'd1);

      $display("[TB] twenty requests into a sixteen-slot log");
      clearPulse();
      mode = 2'd1; num_request = 100;
      for (int i = 0; i < 20; i++) begin
         arvalid = 1; arready = 1; arid = (i < 16) ? 12'(i) : 12'(i + 8); tick();
      end
      tick();
      cmp("t6 req_cnt", req_cnt, 64'd20);
      cmp("t6 req_log", req_id_log, 64'hFEDC_BA98_7654_3210);

      $display("[TB] randomized traffic");
      for (int r = 0; r < 14; r++) begin
         mode = (r % 7 == 6) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
         num_request = 64'($urandom_range(0, 10));
         clearPulse();
         for (int c = 0; c < 200; c++) applyStimulus();
      end

      reset_n = 0; tick(); reset_n = 1; tick();
      chkEn = 0;
      $display("test done: total=%0d bad=%0d", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/axi_lat_profiler.md
Name: axi_lat_profiler

Overview:
- Parametrised AXI transaction latency profiler; successor to the single-mode counter used by the CXL AFU test cases.
- Passively taps one AXI master port, read or write channel set selected at run time.
- Measures:
  - total window: first request handshake to last response handshake.
  - first-response latency.
  - per-request latency min/max/sum, tracked per ID via a timestamp table.
  - ordered request/response ID logs of configurable depth.
  - protocol error flags.
- Results are read back by the AFU CSR block.

Parameters:
- ID_W, 12, AXI ID width on ar/aw/r/b.
- NUM_IDS, 16, timestamp table entries; indexed by id[$clog2(NUM_IDS)-1:0].
- LOG_DEPTH, 16, number of ID log slots.
- LOG_ID_W, 4, ID bits kept per log slot.
- CNT_W, 64, width of all counters and results.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- clear  in  1  synchronous clear of all state and results; same effect as reset
- mode  in  2  0 idle, 1 read (AR/R), 2 write (AW/B), 3 reserved (behaves as idle)
- num_request  in  CNT_W  responses expected; 0 treated as 1
- arvalid, arready, awvalid, awready  in  1 each  address handshakes
- arid, awid  in  ID_W  address IDs
- rvalid, rready, rlast  in  1 each  read data handshake and last beat
- rid  in  ID_W  read data ID
- wvalid, wready  in  1 each  write data handshake
- bvalid, bready  in  1 each  write response handshake
- bid  in  ID_W  write response ID
- busy  out  1  state == CNT
- done  out  1  state == DONE
- total_cycles  out  CNT_W  window length
- first_resp_cycles  out  CNT_W  latency of first response
- lat_min, lat_max, lat_sum  out  CNT_W  per-request latency statistics
- req_cnt, resp_cnt, beat_cnt  out  CNT_W  request, response and data-beat counts
- req_id_log, resp_id_log  out  LOG_DEPTH*LOG_ID_W  packed ID logs; slot k at bits [k*LOG_ID_W +: LOG_ID_W]
- err_orphan, err_dup  out  1  sticky error flags

Behaviour:
- Reset or clear: all outputs 0, lat_min all-ones, state IDLE, table entries invalid, free-running cycle counter now = 0.
- Changing mode while busy: implementation takes no action; software must pulse clear.
- Channel mapping:
  - req = ar handshake (mode 1) or aw handshake (mode 2).
  - resp = r handshake with rlast (mode 1) or b handshake (mode 2).
  - beat = r handshake (mode 1) or w handshake (mode 2).
- Counters: req_cnt, beat_cnt and resp_cnt increment on every qualifying handshake in states IDLE and CNT; frozen in DONE and in modes 0/3.
- State machine:
  - IDLE → CNT on first req.
  - CNT → DONE on the resp that brings resp_cnt to num_request.
  - DONE holds until clear.
- Window timing:
  - total_cycles = 0 on the first-req cycle and increments every cycle in CNT, including the final resp cycle.
  - Result equals T(last resp) − T(first req).
  - first_resp_cycles increments alongside total_cycles while resp_cnt == 0.
- Timestamp table:
  - On req: entry[id] = {valid=1, stamp=now}. If already valid, set err_dup and overwrite.
  - On resp with entry[rid/bid] valid: lat = now − stamp. Update lat_min/lat_max/lat_sum (lat_sum wraps modulo 2^CNT_W), then invalidate the entry.
  - On resp with entry invalid: set err_orphan; statistics unchanged; resp_cnt still increments.
  - req and resp with the same index in the same cycle: the resp retires the old entry using the old stamp; the req then allocates the new entry.
- ID logs:
  - Slot req_cnt gets id[LOG_ID_W-1:0] on req; slot resp_cnt gets the resp ID on resp.
  - Writes at index ≥ LOG_DEPTH are dropped.
- All outputs are registered; statistics and logs are visible 1 cycle after the handshake.
- IDs wider than $clog2(NUM_IDS) alias; aliasing surfaces as err_dup.

Decomposition:
- Package axi_lat_pkg:
  - mode_e (IDLE, RD, WR, RSVD)
  - state_e (IDLE, CNT, DONE)
  - default LOG_ID_W
- Sub-module lat_id_table:
  - NUM_IDS valid/stamp array with one alloc port and one retire port.
  - Retire read is combinational; dup and orphan flags are outputs.
  - Implements the same-cycle retire-before-alloc ordering.

Test Plan:
- mode=1, num_request=4, IDs 0–3 issued back-to-back at t=0..3, rlast responses at t=20,21,22,23 → done, total_cycles=23, first_resp_cycles=20, lat_min=20, lat_max=20, lat_sum=80, req_id_log[15:0]=0x3210.
- mode=2, num_request=2, aw id5 at t=0, w beats, b id5 at t=10, aw id5 again at t=10, b at t=30 → lat_min=10, lat_max=20, err_dup=0, resp_id_log[7:0]=0x55.
- mode=1, 4-beat burst id2 → beat_cnt=4, resp_cnt=1, a single latency sample.
- b id7 with no outstanding request → err_orphan=1, lat_sum unchanged, resp_cnt=1.
- Clear asserted mid-CNT with 3 entries outstanding → next cycle all outputs 0, lat_min all-ones, state IDLE; a later response on those IDs sets err_orphan.
- 20 requests with LOG_DEPTH=16 → slots 0–15 logged, requests 16–19 not logged, req_cnt=20.
